ws2812b_frame_scheduler: RTL and testbench
==========================================

# ws2812b_frame_scheduler

Frame sequencer between the TinyQV host registers and the `ws2812b` serializer. It holds an indexed framebuffer (NUM_LEDS pixels, 2-bit index each) and a 4-entry 24-bit GRB palette. On a start request or an auto-refresh tick, it streams one full frame to the serializer through its valid/ready/latch handshake. The host no longer has to spoon-feed pixels. The block only arbitrates between explicit starts and timed refresh.

## Interface
- NUM_LEDS, 16, pixels per frame (2..64); AW = $clog2(NUM_LEDS)
- REFRESH_W, 16, width of refresh period counter
- clk  in  1  system clock (64 MHz nominal)
- rst_n  in  1  reset; asynchronous, active-low
- pal_we  in  1  palette write strobe
- pal_sel  in  2  palette entry to write
- pal_color  in  24  GRB colour {G,R,B}
- pix_we  in  1  pixel index write strobe
- pix_addr  in  AW  pixel to write; values >= NUM_LEDS ignored
- pix_idx  in  2  palette index for pixel
- start  in  1  request one frame (level sampled each cycle)
- auto_en  in  1  enable timed refresh
- refresh_period  in  REFRESH_W  idle cycles between frames in auto mode
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of frame
- drv_data  out  24  pixel colour to serializer
- drv_valid  out  1  pixel offered to serializer
- drv_latch  out  1  last pixel of frame; serializer emits reset gap after it
- drv_ready  in  1  serializer idle and able to accept

## Operation
- Reset values: all palette entries 0, all pixel indices 0, drv_data 0, drv_valid 0, drv_latch 0, busy 0, frame_done 0, pointer 0, refresh counter 0, pending 0. Reset is asynchronous, so drv_valid drops immediately even mid-frame.
- Writes to the palette and pixel arrays are accepted in any state, every cycle.
- Both writes can occur in the same cycle.
- A pixel's colour is resolved at issue time: palette[pix[ptr]] captured into drv_data. If a write to the same pixel or entry lands on the issue edge, the old value is issued.
- States:
  - IDLE
    - start=1 → ISSUE, ptr=0, busy=1.
    - Otherwise, if auto_en=1 and counter==refresh_period → ISSUE and counter cleared; else counter increments.
    - counter is held at 0 while auto_en=0.
  - ISSUE: on the first edge with drv_ready=1, set drv_valid=1, load drv_data, and set drv_latch=(ptr==NUM_LEDS-1) → ACCEPT.
  - ACCEPT: drv_valid and drv_latch are held. On the first edge with drv_ready=0, clear both.
    - If ptr==NUM_LEDS-1 → DONE.
    - Otherwise ptr+1 → ISSUE.
  - DONE: on the first edge with drv_ready=1, frame_done=1 for one cycle and counter cleared.
    - If pending=1: clear pending, ptr=0, stay busy → ISSUE.
    - Otherwise busy=0 → IDLE.
- start while busy sets pending; further starts while pending are absorbed, so at most one frame is queued.
- start and an auto tick in the same IDLE cycle launch one frame only.
- Auto ticks are never queued while busy.
- refresh_period=0 with auto_en=1 gives back-to-back frames: IDLE lasts one cycle.
- drv_latch is never high without drv_valid.

## Timing
- start sampled high at edge t: busy=1 after t; drv_valid=1 after t+1 at the earliest (drv_ready=1).
- Per pixel: ISSUE→ACCEPT takes one edge with ready high. ACCEPT exits on the edge where ready is sampled low. Pixel throughput is set by the serializer.
- frame_done rises one cycle after drv_ready returns high following the last pixel; busy falls in the same cycle unless pending.
- In auto mode, the gap from frame_done to the next busy is refresh_period+1 cycles.

## Test plan
- **Single frame.** NUM_LEDS=4. Palette 0=000000, 1=FF0000, 2=00FF00, 3=0000FF; pixels {1,2,3,0}; pulse start. Use a serializer model that drops ready 2 cycles after valid and restores it 10 cycles later.
  - Required: drv_data sequence FF0000, 00FF00, 0000FF, 000000.
  - drv_latch=1 only with the 4th pixel.
  - One frame_done pulse; busy low afterwards.
- **Queued start.** start during pixel 2, then start again during pixel 3.
  - Required: exactly two frames, no IDLE cycle between them, two frame_done pulses.
- **Auto refresh.** auto_en=1, refresh_period=20, serializer always fast.
  - Required: each frame starts 21 cycles after the previous frame_done.
  - Clearing auto_en in IDLE stops further frames.
- **Write hazard.** Write palette[1]=123456 on the exact edge pixel 0 (index 1) issues.
  - Required: pixel 0 is issued as FF0000; the next frame issues 123456.
- **Reset mid-frame.** Assert rst_n low while drv_valid=1 on pixel 2.
  - Required: drv_valid, drv_latch and busy are 0 asynchronously; palette reads back 0; no frame_done.
  - After release, start produces a frame of 000000 pixels.
- **Stalled serializer.** Hold drv_ready=0 before start.
  - Required: busy=1 and drv_valid stays 0 until ready rises, then normal sequence.
  - Out-of-range pix_addr writes do not alter any pixel.

Source files
------------

// File: rtl/ws2812b_frame_scheduler_if.sv
// Pixel handshake between the frame scheduler and the ws2812b serializer.
// The scheduler offers one colour at a time; the serializer paces it with drv_ready.
interface ws2812b_frame_scheduler_if;
  logic [23:0] drv_data;
  logic        drv_valid;
  logic        drv_latch;
  logic        drv_ready;

  modport master (output drv_data, output drv_valid, output drv_latch, input drv_ready);
  modport slave  (input drv_data, input drv_valid, input drv_latch, output drv_ready);
endinterface

// File: rtl/ws2812b_frame_scheduler.sv
// Indexed framebuffer + 4-entry GRB palette; streams whole frames to the ws2812b
// serializer on an explicit start or a timed auto-refresh tick.
module ws2812b_frame_scheduler #(
  parameter int NUM_LEDS  = 16,
  parameter int REFRESH_W = 16,
  localparam int AW       = $clog2(NUM_LEDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pal_we,
  input  logic [1:0]           pal_sel,
  input  logic [23:0]          pal_color,
  input  logic                 pix_we,
  input  logic [AW-1:0]        pix_addr,
  input  logic [1:0]           pix_idx,
  input  logic                 start,
  input  logic                 auto_en,
  input  logic [REFRESH_W-1:0] refresh_period,
  output logic                 busy,
  output logic                 frame_done,
  ws2812b_frame_scheduler_if.master drv
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_ACCEPT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(NUM_LEDS - 1);
  localparam logic [AW:0]   LED_CNT  = (AW + 1)'(NUM_LEDS);

  logic [23:0]          pal_r [4];
  logic [1:0]           pix_r [NUM_LEDS];

  state_t               state_r, state_s;
  logic [AW-1:0]        ptr_r, ptr_s;
  logic [REFRESH_W-1:0] cnt_r, cnt_s;
  logic                 pending_r, pending_s;
  logic                 busy_r, busy_s;
  logic                 frame_done_r, frame_done_s;
  logic [23:0]          drv_data_r, drv_data_s;
  logic                 drv_valid_r, drv_valid_s;
  logic                 drv_latch_r, drv_latch_s;

  // Palette and framebuffer write ports, open in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pal_r[i] <= 24'h000000;
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
        pix_r[i] <= 2'b00;
      end
    end else begin
      if (pal_we) begin
        pal_r[pal_sel] <= pal_color;
      end
      if (pix_we && ({1'b0, pix_addr} < LED_CNT)) begin
        pix_r[pix_addr] <= pix_idx;
      end
    end
  end

  // Sequencer next-state and registered-output values
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    cnt_s        = cnt_r;
    busy_s       = busy_r;
    frame_done_s = 1'b0;
    drv_data_s   = drv_data_r;
    drv_valid_s  = drv_valid_r;
    drv_latch_s  = drv_latch_r;
    // A start seen mid-frame queues at most one follow-up frame
    if (busy_r && start) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start || (auto_en && (cnt_r == refresh_period))) begin
          state_s = ST_ISSUE;
          ptr_s   = {AW{1'b0}};
          busy_s  = 1'b1;
          cnt_s   = {REFRESH_W{1'b0}};
        end else if (auto_en) begin
          cnt_s = cnt_r + REFRESH_W'(1);
        end else begin
          cnt_s = {REFRESH_W{1'b0}};
        end
      end
      ST_ISSUE: begin
        if (drv.drv_ready) begin
          drv_valid_s = 1'b1;
          drv_data_s  = pal_r[pix_r[ptr_r]];
          drv_latch_s = (ptr_r == LAST_PTR);
          state_s     = ST_ACCEPT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_ACCEPT: begin
        if (!drv.drv_ready) begin
          drv_valid_s = 1'b0;
          drv_latch_s = 1'b0;
          if (ptr_r == LAST_PTR) begin
            state_s = ST_DONE;
          end else begin
            ptr_s   = ptr_r + AW'(1);
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_ACCEPT;
        end
      end
      ST_DONE: begin
        if (drv.drv_ready) begin
          frame_done_s = 1'b1;
          cnt_s        = {REFRESH_W{1'b0}};
          if (pending_r || start) begin
            pending_s = 1'b0;
            ptr_s     = {AW{1'b0}};
            state_s   = ST_ISSUE;
          end else begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        busy_s      = 1'b0;
        drv_valid_s = 1'b0;
        drv_latch_s = 1'b0;
      end
    endcase
  end

  // Sequencer state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      ptr_r        <= {AW{1'b0}};
      cnt_r        <= {REFRESH_W{1'b0}};
      pending_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      drv_data_r   <= 24'h000000;
      drv_valid_r  <= 1'b0;
      drv_latch_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      cnt_r        <= cnt_s;
      pending_r    <= pending_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      drv_data_r   <= drv_data_s;
      drv_valid_r  <= drv_valid_s;
      drv_latch_r  <= drv_latch_s;
    end
  end

  assign busy          = busy_r;
  assign frame_done    = frame_done_r;
  assign drv.drv_data  = drv_data_r;
  assign drv.drv_valid = drv_valid_r;
  assign drv.drv_latch = drv_latch_r;

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Scoreboard bench: stimulus pushes expected pixels, monitors pop and compare on each new pixel.
module tb_ws2812b_frame_scheduler;

  typedef struct packed {
    logic [23:0] data;
    logic        latch;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pal_we = 1'b0, pix_we = 1'b0, start = 1'b0, auto_en = 1'b0;
  logic [1:0]  pal_sel = 2'd0, pix_addr = 2'd0, pix_idx = 2'd0;
  logic [23:0] pal_color = 24'h0;
  logic [15:0] refresh_period = 16'd0;
  logic        busy, frame_done;
  logic        rdy = 1'b1;

  logic        pal_we5 = 1'b0, pix_we5 = 1'b0, start5 = 1'b0;
  logic [1:0]  pal_sel5 = 2'd0, pix_idx5 = 2'd0;
  logic [2:0]  pix_addr5 = 3'd0;
  logic [23:0] pal_color5 = 24'h0;
  logic        busy5, frame_done5;
  logic        rdy5 = 1'b1;

  ws2812b_frame_scheduler_if drv ();
  ws2812b_frame_scheduler_if drv5 ();
  assign drv.drv_ready  = rdy;
  assign drv5.drv_ready = rdy5;

  ws2812b_frame_scheduler #(.NUM_LEDS(4), .REFRESH_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .pal_we(pal_we), .pal_sel(pal_sel), .pal_color(pal_color),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_idx(pix_idx), .start(start),
    .auto_en(auto_en), .refresh_period(refresh_period), .busy(busy),
    .frame_done(frame_done), .drv(drv)
  );

  ws2812b_frame_scheduler #(.NUM_LEDS(5), .REFRESH_W(16)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .pal_we(pal_we5), .pal_sel(pal_sel5), .pal_color(pal_color5),
    .pix_we(pix_we5), .pix_addr(pix_addr5), .pix_idx(pix_idx5), .start(start5),
    .auto_en(1'b0), .refresh_period(16'd0), .busy(busy5),
    .frame_done(frame_done5), .drv(drv5)
  );

  always #5 clk = ~clk;

  int   total = 0, bad = 0;
  int   cyc = 0, pix_seen = 0, fd_cnt = 0, fd5_cnt = 0, busy_rise = 0, busy_fall = 0;
  int   last_fd = -1;
  bit   auto_chk = 1'b0;
  logic prev_valid = 1'b0, prev_busy = 1'b0, prev_valid5 = 1'b0;
  pix_t exp_q[$];
  pix_t exp5_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Serializer model: ser_drop cycles after a pixel appears ready drops for ser_len cycles
  int ser_drop = 1, ser_len = 1, scnt = 0, phase = 0;
  bit ser_hold = 1'b0;
  always @(negedge clk) begin
    if (ser_hold) begin
      rdy = 1'b0;
      phase = 0;
    end else begin
      case (phase)
        0: if (!rdy) rdy = 1'b1;
           else if (drv.drv_valid) begin phase = 1; scnt = ser_drop; end
        1: begin scnt--; if (scnt <= 0) begin rdy = 1'b0; scnt = ser_len; phase = 2; end end
        2: begin scnt--; if (scnt <= 0) begin rdy = 1'b1; phase = 0; end end
        default: phase = 0;
      endcase
    end
  end

  // Main DUT monitor
  always @(negedge clk) begin
    pix_t e;
    if (rst_n) begin
      if (drv.drv_latch && !drv.drv_valid) chk("latch_without_valid", 32'd1, 32'd0);
      if (drv.drv_valid && !prev_valid) begin
        pix_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", {8'h0, drv.drv_data}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pix_data", {8'h0, drv.drv_data}, {8'h0, e.data});
          chk("pix_latch", {31'h0, drv.drv_latch}, {31'h0, e.latch});
        end
      end
      if (frame_done) begin fd_cnt++; last_fd = cyc; end
      if (busy && !prev_busy) begin
        busy_rise++;
        if (auto_chk && last_fd >= 0) chk("auto_gap", cyc - last_fd, 32'd21);
      end
      if (!busy && prev_busy) busy_fall++;
      prev_valid = drv.drv_valid;
      prev_busy  = busy;
    end else begin
      prev_valid = 1'b0;
      prev_busy  = 1'b0;
    end
  end

  // Second DUT (NUM_LEDS=5) monitor with an always-fast serializer
  always @(negedge clk) begin
    pix_t e;
    if (rst_n) begin
      if (drv5.drv_valid && !prev_valid5) begin
        if (exp5_q.size() == 0) begin
          chk("unexpected_pixel5", {8'h0, drv5.drv_data}, 32'hFFFFFFFF);
        end else begin
          e = exp5_q.pop_front();
          chk("pix5_data", {8'h0, drv5.drv_data}, {8'h0, e.data});
          chk("pix5_latch", {31'h0, drv5.drv_latch}, {31'h0, e.latch});
        end
      end
      if (frame_done5) fd5_cnt++;
      prev_valid5 = drv5.drv_valid;
    end else begin
      prev_valid5 = 1'b0;
    end
    rdy5 = !drv5.drv_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wr_pal(input logic [1:0] sel, input logic [23:0] c);
    pal_sel = sel; pal_color = c; pal_we = 1'b1; tick(1); pal_we = 1'b0;
  endtask

  task automatic wr_pix(input logic [1:0] a, input logic [1:0] idx);
    pix_addr = a; pix_idx = idx; pix_we = 1'b1; tick(1); pix_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic push_frame(input logic [23:0] c0, c1, c2, c3);
    exp_q.push_back({c0, 1'b0});
    exp_q.push_back({c1, 1'b0});
    exp_q.push_back({c2, 1'b0});
    exp_q.push_back({c3, 1'b1});
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin tick(1); n++; end
    if (fd_cnt < target) chk("wait_frame_done", fd_cnt, target);
  endtask

  task automatic wait_pix(input int target, input int budget);
    int n = 0;
    while (pix_seen < target && n < budget) begin tick(1); n++; end
    if (pix_seen < target) chk("wait_pixel", pix_seen, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, bf0, br0, ps0;

    // Reset values
    tick(1);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'd0);
    chk("rst_valid", {31'h0, drv.drv_valid}, 32'd0);
    chk("rst_latch", {31'h0, drv.drv_latch}, 32'd0);
    chk("rst_data", {8'h0, drv.drv_data}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single frame, slow serializer
    ser_drop = 2; ser_len = 10;
    wr_pal(2'd0, 24'h000000); wr_pal(2'd1, 24'hFF0000);
    wr_pal(2'd2, 24'h00FF00); wr_pal(2'd3, 24'h0000FF);
    wr_pix(2'd0, 2'd1); wr_pix(2'd1, 2'd2); wr_pix(2'd2, 2'd3); wr_pix(2'd3, 2'd0);
    push_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000);
    fd0 = fd_cnt;
    pulse_start();
    chk("start_busy", {31'h0, busy}, 32'd1);
    wait_fd(fd0 + 1, 500);
    chk("single_busy_at_done", {31'h0, busy}, 32'd0);
    tick(20);
    chk("single_done_count", fd_cnt - fd0, 32'd1);
    chk("single_queue_empty", exp_q.size(), 32'd0);

    // Queued start: second start is absorbed, frames run back-to-back
    push_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000);
    push_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000);
    fd0 = fd_cnt; bf0 = busy_fall; ps0 = pix_seen;
    pulse_start();
    wait_pix(ps0 + 2, 200);
    pulse_start();
    wait_pix(ps0 + 3, 200);
    pulse_start();
    wait_fd(fd0 + 2, 1000);
    tick(40);
    chk("queued_done_count", fd_cnt - fd0, 32'd2);
    chk("queued_busy_falls", busy_fall - bf0, 32'd1);
    chk("queued_queue_empty", exp_q.size(), 32'd0);

    // Auto refresh, fast serializer
    ser_drop = 1; ser_len = 1;
    for (int f = 0; f < 3; f++) push_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000);
    refresh_period = 16'd20;
    last_fd = -1; auto_chk = 1'b1;
    fd0 = fd_cnt;
    auto_en = 1'b1;
    wait_fd(fd0 + 3, 1000);
    auto_en = 1'b0;
    br0 = busy_rise;
    tick(60);
    auto_chk = 1'b0;
    chk("auto_stopped", busy_rise - br0, 32'd0);
    chk("auto_queue_empty", exp_q.size(), 32'd0);

    // Write hazard: palette[1] rewritten on the edge pixel 0 issues
    push_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000);
    push_frame(24'h123456, 24'h00FF00, 24'h0000FF, 24'h000000);
    fd0 = fd_cnt;
    start = 1'b1; tick(1); start = 1'b0;
    pal_sel = 2'd1; pal_color = 24'h123456; pal_we = 1'b1; tick(1); pal_we = 1'b0;
    wait_fd(fd0 + 1, 200);
    pulse_start();
    wait_fd(fd0 + 2, 200);
    tick(5);
    chk("hazard_queue_empty", exp_q.size(), 32'd0);

    // Reset mid-frame while pixel 2 is offered
    ser_drop = 2; ser_len = 10;
    push_frame(24'h123456, 24'h00FF00, 24'h0000FF, 24'h000000);
    ps0 = pix_seen;
    pulse_start();
    wait_pix(ps0 + 3, 200);
    chk("pre_reset_valid", {31'h0, drv.drv_valid}, 32'd1);
    fd0 = fd_cnt;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'h0, drv.drv_valid}, 32'd0);
    chk("async_latch", {31'h0, drv.drv_latch}, 32'd0);
    chk("async_busy", {31'h0, busy}, 32'd0);
    exp_q.delete();
    tick(20);
    rst_n = 1'b1;
    tick(2);
    chk("reset_no_done", fd_cnt - fd0, 32'd0);
    wr_pix(2'd0, 2'd1); wr_pix(2'd1, 2'd2); wr_pix(2'd2, 2'd3); wr_pix(2'd3, 2'd3);
    push_frame(24'h000000, 24'h000000, 24'h000000, 24'h000000);
    pulse_start();
    wait_fd(fd0 + 1, 500);
    tick(15);
    chk("reset_queue_empty", exp_q.size(), 32'd0);

    // Stalled serializer before start
    ser_drop = 1; ser_len = 1;
    wr_pal(2'd1, 24'hFF0000); wr_pal(2'd2, 24'h00FF00); wr_pal(2'd3, 24'h0000FF);
    push_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h0000FF);
    ser_hold = 1'b1;
    tick(2);
    ps0 = pix_seen; fd0 = fd_cnt;
    pulse_start();
    tick(20);
    chk("stall_busy", {31'h0, busy}, 32'd1);
    chk("stall_valid", {31'h0, drv.drv_valid}, 32'd0);
    chk("stall_no_pixel", pix_seen - ps0, 32'd0);
    ser_hold = 1'b0;
    wait_fd(fd0 + 1, 300);
    chk("stall_busy_at_done", {31'h0, busy}, 32'd0);
    tick(5);
    chk("stall_queue_empty", exp_q.size(), 32'd0);

    // Out-of-range pixel writes on a 5-LED instance
    pal_sel5 = 2'd0; pal_color5 = 24'h111111; pal_we5 = 1'b1; tick(1);
    pal_sel5 = 2'd2; pal_color5 = 24'h222222; tick(1);
    pal_sel5 = 2'd3; pal_color5 = 24'hABCDEF; tick(1);
    pal_we5 = 1'b0;
    pix_we5 = 1'b1;
    pix_addr5 = 3'd4; pix_idx5 = 2'd2; tick(1);
    for (int a = 5; a < 8; a++) begin pix_addr5 = 3'(a); pix_idx5 = 2'd3; tick(1); end
    pix_we5 = 1'b0;
    for (int i = 0; i < 4; i++) exp5_q.push_back({24'h111111, 1'b0});
    exp5_q.push_back({24'h222222, 1'b1});
    start5 = 1'b1; tick(1); start5 = 1'b0;
    begin
      int n = 0;
      while (fd5_cnt < 1 && n < 200) begin tick(1); n++; end
    end
    chk("oor_done_count", fd5_cnt, 32'd1);
    chk("oor_busy", {31'h0, busy5}, 32'd0);
    chk("oor_queue_empty", exp5_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
